// File: rtl/safe_feeder_pkg.sv
// Shared types and constants for the safe checker feeder.
package safe_feeder_pkg;

  localparam int DEPTH = 8;
  localparam logic [7:0] CHAR_MIN = 8'h20;
  localparam logic [7:0] CHAR_MAX = 8'h7E;

  typedef enum logic [1:0] {COLLECT, PRIME, ARMED} state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_MIN) && (c <= CHAR_MAX);
  endfunction

endpackage

// File: rtl/safe_feeder_buf.sv
// Password register file: one write port, one registered read port.
// A deasserted re loads zero so the top sees data=0 outside replay.
module safe_feeder_buf #(
  parameter int DEPTH  = 8,
  parameter int CHAR_W = 7,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [CHAR_W-1:0] rdata
);

  logic [CHAR_W-1:0] mem [DEPTH];

  // Contents are never cleared; a new password simply overwrites them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/safe_feeder.sv
// Collects eight characters, then replays them forever to the safe checker.
// Optional SAFE_FEEDER_FILTER_EN drops non-printable bytes and flags err.
module safe_feeder
  import safe_feeder_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CHAR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_char,
  output logic              in_ready,
  input  logic              clear,
  output logic [CHAR_W-1:0] data,
  output logic              armed,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, nxt;
  logic [AW-1:0] count, rp;
  logic          xfer, store, char_ok;

  assign in_ready = rst_n && (state == COLLECT) && !clear;
  assign xfer     = in_valid && in_ready;

`ifdef SAFE_FEEDER_FILTER_EN
  assign char_ok = is_printable(in_char);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err <= 1'b0;
    else if (clear)            err <= 1'b0;
    else if (xfer && !char_ok) err <= 1'b1;
  end
`else
  logic unused_msb;
  assign unused_msb = in_char[7];
  assign char_ok    = 1'b1;
  assign err        = 1'b0;
`endif

  assign store = xfer && char_ok;

  always_comb begin
    nxt = state;
    case (state)
      COLLECT: if (store && count == LAST) nxt = PRIME;
      PRIME:   if (rp == LAST) nxt = ARMED;
      ARMED:   nxt = ARMED;
      default: nxt = COLLECT;
    endcase
    if (clear) nxt = COLLECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      count <= '0;
      rp    <= '0;
      armed <= 1'b0;
    end else begin
      state <= nxt;
      if (clear)      count <= '0;
      else if (store) count <= count + 1'b1;
      // rp free-runs through PRIME and ARMED so the replay loop never breaks
      if (clear || state == COLLECT) rp <= '0;
      else                           rp <= rp + 1'b1;
      // registered one edge after ARMED: the checker's last write lands then
      armed <= !clear && (state == ARMED);
    end
  end

  safe_feeder_buf #(.DEPTH(DEPTH), .CHAR_W(CHAR_W)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (store),
    .waddr (count),
    .wdata (in_char[CHAR_W-1:0]),
    .re    ((state != COLLECT) && !clear),
    .raddr (rp),
    .rdata (data)
  );

endmodule

// File: tb/tb_safe_feeder.sv
// Directed bench for safe_feeder with a looped checker memory model.
module tb_safe_feeder;

`ifdef SAFE_FEEDER_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       clear = 1'b0;
  logic       in_ready;
  logic [6:0] data;
  logic       armed;
  logic       err;

  int passed = 0;
  int total  = 0;

  safe_feeder #(.DEPTH(8), .CHAR_W(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_ready (in_ready),
    .clear    (clear),
    .data     (data),
    .armed    (armed),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Checker memory models: write index steps by 5 mod 8, two start phases.
  logic [7:0][6:0] m0, m1, s0, s1;
  logic [2:0] i0 = 3'd0;
  logic [2:0] i1 = 3'd3;
  always @(posedge clk) begin
    m0[i0] <= data;
    m1[i1] <= data;
    i0 <= i0 + 3'd5;
    i1 <= i1 + 3'd5;
  end

  function automatic int csum(input logic [7:0][6:0] m);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'(m[k]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    #1 chk("in_ready_on_send", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input logic [63:0] s);
    for (int k = 0; k < 8; k++) send(s[63-8*k -: 8]);
  endtask

  // Called right after the 8th accept edge; checks PRIME, armed rise, loop.
  task automatic replay_check(input logic [63:0] s);
    logic [7:0] b;
    chk("in_ready_prime", 64'(in_ready), 64'd0);
    chk("data_after_e0", 64'(data), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b = s[63-8*k -: 8];
      chk("replay_prime", 64'(data), 64'(b[6:0]));
      chk("armed_low", 64'(armed), 64'd0);
    end
    @(negedge clk);
    b = s[63 -: 8];
    chk("armed_e9", 64'(armed), 64'd1);
    chk("replay_loop0", 64'(data), 64'(b[6:0]));
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      b = s[63-8*k -: 8];
      chk("replay_loop", 64'(data), 64'(b[6:0]));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_armed", 64'(armed), 64'd0);
    chk("clr_data", 64'(data), 64'd0);
    chk("clr_err", 64'(err), 64'd0);
  endtask

  initial begin
    // reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // "Ph0t0n!x" back-to-back
    send_str(64'h5068_3074_306E_2178);
    replay_check(64'h5068_3074_306E_2178);

    // ABCDEFGH with looped checker: memory stable for 32 armed cycles
    do_clear();
    send_str(64'h4142_4344_4546_4748);
    replay_check(64'h4142_4344_4546_4748);
    s0 = m0;
    s1 = m1;
    chk("mem0_sum", 64'(csum(m0)), 64'd548);
    chk("mem1_sum", 64'(csum(m1)), 64'd548);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("mem0_stable", 64'(m0), 64'(s0));
      chk("mem1_stable", 64'(m1), 64'(s1));
    end

    // partial buffer, clear with a simultaneous offer, then a new password
    do_clear();
    for (int k = 0; k < 5; k++) send(8'h61 + 8'(k));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_char  = 8'h7A;
    #1 chk("clear_blocks_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("mid_clr_data", 64'(data), 64'd0);
    chk("mid_clr_armed", 64'(armed), 64'd0);
    send_str(64'h3132_3334_3536_3738);
    replay_check(64'h3132_3334_3536_3738);

    // filter behaviour on 0x0A
    do_clear();
    send(8'h41);
    send(8'h0A);
    chk("err_after_0a", 64'(err), 64'(FILT));
`ifdef SAFE_FEEDER_FILTER_EN
    for (int k = 0; k < 7; k++) send(8'h42 + 8'(k));
    replay_check(64'h4142_4344_4546_4748);
`else
    for (int k = 0; k < 6; k++) send(8'h42 + 8'(k));
    replay_check(64'h410A_4243_4445_4647);
`endif
    chk("err_sticky", 64'(err), 64'(FILT));

    // asynchronous reset while armed
    #2 rst_n = 1'b0;
    #1;
    chk("arst_armed", 64'(armed), 64'd0);
    chk("arst_data", 64'(data), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel_ready", 64'(in_ready), 64'd1);
    chk("arst_rel_data", 64'(data), 64'd0);
    @(negedge clk);

    // bit 7 set
    send(8'hC1);
    chk("err_c1", 64'(err), 64'(FILT));
`ifdef SAFE_FEEDER_FILTER_EN
    for (int k = 0; k < 8; k++) send(8'h41 + 8'(k));
`else
    for (int k = 0; k < 7; k++) send(8'h42 + 8'(k));
`endif
    replay_check(64'h4142_4344_4546_4748);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
